// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, per-source enable, lowest-index priority.
// Optional level-sensitive sources are enabled with the IRQ_CTRL_LEVEL_EN macro.
module irq_ctrl #(
  parameter int unsigned addr_bits   = 3,
  parameter int unsigned num_sources = 16
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [addr_bits-1:0]   READ_ADDR,
  output logic [31:0]            DATA_OUT,
  output logic                   DATA_VALID,
  input  logic                   OE,
  input  logic [addr_bits-1:0]   WRITE_ADDR,
  input  logic [31:0]            DATA_IN,
  input  logic [3:0]             BE,
  input  logic                   WE,
  output logic                   WACK,
  input  logic [num_sources-1:0] src_i,
  output logic                   irq_o,
  output logic [4:0]             irq_id_o,
  input  logic                   irq_ack_i,
  input  logic [4:0]             irq_ack_id_i
);

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] SRC_MASK = DATA_W'((64'd1 << num_sources) - 64'd1);

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_ENABLE  = 3'd1;
  localparam logic [2:0] A_RAW     = 3'd2;
  localparam logic [2:0] A_CLAIM   = 3'd3;
  localparam logic [2:0] A_SWSET   = 3'd4;
  localparam logic [2:0] A_MODE    = 3'd5;

  logic [DATA_W-1:0] src_w;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] pending;
  logic [DATA_W-1:0] enable;
  logic [DATA_W-1:0] mode;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] rise;
  logic [DATA_W-1:0] bmask;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] w1c;
  logic [DATA_W-1:0] swset;
  logic [DATA_W-1:0] ackclr;
  logic [DATA_W-1:0] pend_edge;
  logic [DATA_W-1:0] pend_nxt;
  logic [DATA_W-1:0] rdata;
  logic [2:0]        ra;
  logic [2:0]        wa;

  // Write decode, edge detect and pending next-state
  always_comb begin
    src_w  = DATA_W'(src_i) & SRC_MASK;
    ra     = READ_ADDR[2:0];
    wa     = WRITE_ADDR[2:0];
    bmask  = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
    wmask  = DATA_IN & bmask & SRC_MASK;
    w1c    = (WE && (wa == A_PENDING)) ? wmask : '0;
    swset  = (WE && (wa == A_SWSET))   ? wmask : '0;
    rise   = src_w & ~src_q;
    ackclr = '0;
    if (irq_ack_i && (DATA_W'(irq_ack_id_i) < num_sources)) begin
      ackclr[irq_ack_id_i] = 1'b1;
    end
    pend_edge = rise | swset | (pending & ~w1c & ~ackclr);
`ifdef IRQ_CTRL_LEVEL_EN
    pend_nxt = ((mode & (src_w | swset)) | (~mode & pend_edge)) & SRC_MASK;
`else
    pend_nxt = pend_edge & SRC_MASK;
`endif
  end

  // Lowest-index active source wins
  always_comb begin
    active   = pending & enable;
    irq_o    = |active;
    irq_id_o = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (active[i]) irq_id_o = 5'(i);
    end
  end

  // Read mux sees pre-write state, so a same-cycle write is not visible
  always_comb begin
    rdata = '0;
    case (ra)
      A_PENDING: rdata = pending;
      A_ENABLE:  rdata = enable;
      A_RAW:     rdata = src_w;
      A_CLAIM:   rdata = {irq_o, 26'b0, irq_id_o};
      A_MODE:    rdata = mode;
      default:   rdata = '0;
    endcase
  end

`ifdef IRQ_CTRL_LEVEL_EN
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      mode <= '0;
    end else if (WE && (wa == A_MODE)) begin
      mode <= (mode & ~bmask) | wmask;
    end
  end
`else
  assign mode = '0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      src_q      <= '0;
      pending    <= '0;
      enable     <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      WACK       <= 1'b0;
    end else begin
      src_q      <= src_w;
      pending    <= pend_nxt;
      if (WE && (wa == A_ENABLE)) enable <= (enable & ~bmask) | wmask;
      DATA_VALID <= OE;
      DATA_OUT   <= OE ? rdata : '0;
      WACK       <= WE;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a per-source array model predicts every output cycle.
module tb_irq_ctrl;

  localparam int unsigned NS = 16;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [2:0]    READ_ADDR;
  logic [31:0]   DATA_OUT;
  logic          DATA_VALID;
  logic          OE;
  logic [2:0]    WRITE_ADDR;
  logic [31:0]   DATA_IN;
  logic [3:0]    BE;
  logic          WE;
  logic          WACK;
  logic [NS-1:0] src_i;
  logic          irq_o;
  logic [4:0]    irq_id_o;
  logic          irq_ack_i;
  logic [4:0]    irq_ack_id_i;

  irq_ctrl #(.addr_bits(3), .num_sources(NS)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .READ_ADDR(READ_ADDR), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .OE(OE),
    .WRITE_ADDR(WRITE_ADDR), .DATA_IN(DATA_IN), .BE(BE), .WE(WE), .WACK(WACK),
    .src_i(src_i), .irq_o(irq_o), .irq_id_o(irq_id_o),
    .irq_ack_i(irq_ack_i), .irq_ack_id_i(irq_ack_id_i)
  );

  always #5 CLK = ~CLK;

  typedef bit arr_t [32];
  typedef struct {
    bit        dv;
    bit [31:0] dout;
    bit        wack;
    bit        irq;
    bit [4:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  arr_t m_pend, m_en, m_mode, m_srcq;

  function automatic void chk(input string name, input bit [31:0] act, input bit [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic bit [31:0] pack(input arr_t a);
    bit [31:0] r = '0;
    for (int i = 0; i < NS; i++) r[i] = a[i];
    return r;
  endfunction

  function automatic void claim(output bit irq, output bit [4:0] id);
    bit found = 0;
    irq = 0;
    id  = '0;
    for (int i = 0; i < NS; i++) begin
      if (!found && m_pend[i] && m_en[i]) begin
        found = 1;
        irq   = 1;
        id    = 5'(i);
      end
    end
  endfunction

  // Model one clock with the inputs currently driven, queue the outputs of the next cycle
  task automatic step();
    exp_t      e;
    bit [31:0] rd;
    bit        c_irq;
    bit [4:0]  c_id;
    arr_t      np, ne, nm;
    e = '{dv: 0, dout: '0, wack: 0, irq: 0, id: '0};
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_srcq[i] = 0;
      end
    end else begin
      claim(c_irq, c_id);
      case (READ_ADDR)
        3'd0: rd = pack(m_pend);
        3'd1: rd = pack(m_en);
        3'd2: rd = 32'(src_i);
        3'd3: rd = {c_irq, 26'b0, c_id};
        3'd5: rd = pack(m_mode);
        default: rd = '0;
      endcase
      e.dv   = OE;
      e.dout = OE ? rd : '0;
      e.wack = WE;
      np = m_pend; ne = m_en; nm = m_mode;
      for (int i = 0; i < NS; i++) begin
        bit wr   = WE && BE[i / 8];
        bit clr  = wr && (WRITE_ADDR == 3'd0) && DATA_IN[i];
        bit set  = wr && (WRITE_ADDR == 3'd4) && DATA_IN[i];
        bit rise = src_i[i] && !m_srcq[i];
        bit ack  = irq_ack_i && (int'(irq_ack_id_i) == i);
        if (m_mode[i]) np[i] = src_i[i] || set;
        else           np[i] = rise || set || (m_pend[i] && !clr && !ack);
        if (wr && (WRITE_ADDR == 3'd1)) ne[i] = DATA_IN[i];
`ifdef IRQ_CTRL_LEVEL_EN
        if (wr && (WRITE_ADDR == 3'd5)) nm[i] = DATA_IN[i];
`endif
        m_srcq[i] = src_i[i];
      end
      m_pend = np; m_en = ne; m_mode = nm;
    end
    claim(e.irq, e.id);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    OE = 0; WE = 0; READ_ADDR = '0; WRITE_ADDR = '0; DATA_IN = '0; BE = '0;
    irq_ack_i = 0; irq_ack_id_i = '0;
  endtask

  task automatic wr(input bit [2:0] a, input bit [31:0] d, input bit [3:0] b);
    WE = 1; WRITE_ADDR = a; DATA_IN = d; BE = b;
    step();
    idle();
  endtask

  task automatic rd(input bit [2:0] a);
    OE = 1; READ_ADDR = a;
    step();
    idle();
  endtask

  task automatic ack(input bit [4:0] id);
    irq_ack_i = 1; irq_ack_id_i = id;
    step();
    idle();
  endtask

  task automatic clean();
    src_i = '0;
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd5, 32'h0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
  endtask

  // Monitor: compare every output cycle against the queued prediction
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_valid", 32'(DATA_VALID), 32'(e.dv));
      chk("data_out",   DATA_OUT,        e.dout);
      chk("wack",       32'(WACK),       32'(e.wack));
      chk("irq_o",      32'(irq_o),      32'(e.irq));
      chk("irq_id_o",   32'(irq_id_o),   32'(e.id));
    end
  end

  initial begin
    bit       c_irq;
    bit [4:0] c_id;
    idle();
    src_i = '0;
    RSTn  = 0;
    step();
    step();
    RSTn = 1;

    // reset values visible through a read
    rd(3'd1);
    step();

    // single edge, ack clears
    wr(3'd1, 32'h10, 4'hF);
    src_i = 16'h0010; step();
    src_i = '0;       step();
    rd(3'd0);
    rd(3'd3);
    ack(5'd4);
    rd(3'd0);
    step();

    // priority and ack of the higher-priority id
    clean();
    wr(3'd1, 32'h12, 4'hF);
    src_i = 16'h0012; step();
    src_i = '0;       step();
    ack(5'd1);
    step();
    ack(5'd4);
    step();

    // set beats W1C, byte-masked W1C
    clean();
    wr(3'd4, 32'h4, 4'hF);
    src_i = 16'h0004;
    WE = 1; WRITE_ADDR = 3'd0; DATA_IN = 32'hFF; BE = 4'h1; OE = 1; READ_ADDR = 3'd0;
    step();
    idle();
    src_i = '0;
    rd(3'd0);
    wr(3'd0, 32'hFF, 4'h2);
    rd(3'd0);

    // held disabled bit fires when enabled, SWSET outranks it
    clean();
    src_i = 16'h0080; step();
    src_i = '0;       step();
    rd(3'd0);
    wr(3'd1, 32'h80, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    rd(3'd3);
    ack(5'd20);
    step();

`ifdef IRQ_CTRL_LEVEL_EN
    clean();
    wr(3'd5, 32'h8, 4'hF);
    src_i = 16'h0008; step();
    wr(3'd0, 32'h8, 4'hF);
    rd(3'd0);
    src_i = '0; step();
    rd(3'd0);
    rd(3'd5);
`endif

    // reset in the middle of a read and write
    OE = 1; WE = 1; READ_ADDR = 3'd1; WRITE_ADDR = 3'd1; DATA_IN = 32'hFFFF; BE = 4'hF;
    RSTn = 0;
    step();
    idle();
    RSTn = 1;
    rd(3'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RSTn         = ($urandom_range(299) != 0);
      OE           = 1'($urandom_range(1));
      READ_ADDR    = 3'($urandom_range(7));
      WE           = ($urandom_range(2) == 0);
      WRITE_ADDR   = 3'($urandom_range(7));
      DATA_IN      = $urandom;
      BE           = 4'($urandom);
      src_i        = src_i ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
      claim(c_irq, c_id);
      irq_ack_i    = ($urandom_range(3) == 0);
      irq_ack_id_i = $urandom_range(1) ? c_id : 5'($urandom_range(31));
      step();
    end
    RSTn = 1;
    idle();
    step();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
